// File: rtl/pattern_gen.sv
// Self-timed video test-pattern source with its own raster timing.
// Patterns, scrolling and start-up blanking are selected per frame.
module pattern_gen #(
  parameter int DATA_WIDTH      = 16,
  parameter int PIXELS_PER_CLK  = 1,
  parameter int H_ACTIVE        = 540,
  parameter int H_SYNC          = 100,
  parameter int H_BP            = 370,
  parameter int H_FP            = 520,
  parameter int V_ACTIVE        = 1920,
  parameter int V_SYNC          = 3,
  parameter int V_BP            = 5,
  parameter int V_FP            = 6,
  parameter int BAR_SHIFT       = 7,
  parameter int BLANK_FRAMES    = 120,
  parameter int FRAME_CNT_WIDTH = 9
) (
  input  logic                                 i_sysclk,
  input  logic                                 i_arst,
  input  logic                                 i_enable,
  input  logic [2:0]                           i_mode,
  input  logic                                 i_scroll_en,
  input  logic [3*DATA_WIDTH-1:0]              i_solid_rgb,
  output logic                                 o_vs,
  output logic                                 o_hs,
  output logic                                 o_de,
  output logic                                 o_valid,
  output logic [15:0]                          o_x,
  output logic [15:0]                          o_y,
  output logic [PIXELS_PER_CLK*DATA_WIDTH-1:0] o_r,
  output logic [PIXELS_PER_CLK*DATA_WIDTH-1:0] o_g,
  output logic [PIXELS_PER_CLK*DATA_WIDTH-1:0] o_b,
  output logic [FRAME_CNT_WIDTH-1:0]           o_frame_cnt,
  output logic                                 o_init_done
);

  localparam int LANE_W = PIXELS_PER_CLK * DATA_WIDTH;
  localparam int SEL_W  = (BAR_SHIFT + 3 > 8) ? BAR_SHIFT + 3 : 8;

  localparam logic [15:0] H_SYNC_END  = 16'(H_SYNC);
  localparam logic [15:0] H_ACT_START = 16'(H_SYNC + H_BP);
  localparam logic [15:0] H_ACT_END   = 16'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [15:0] H_LAST      = 16'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
  localparam logic [15:0] V_SYNC_END  = 16'(V_SYNC);
  localparam logic [15:0] V_ACT_START = 16'(V_SYNC + V_BP);
  localparam logic [15:0] V_ACT_END   = 16'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [15:0] V_LAST      = 16'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
  localparam logic [FRAME_CNT_WIDTH:0] BLANK_LIMIT = (FRAME_CNT_WIDTH + 1)'(BLANK_FRAMES);

  typedef enum logic [2:0] {
    MODE_BARS    = 3'd0,
    MODE_HRAMP   = 3'd1,
    MODE_VRAMP   = 3'd2,
    MODE_CHECKER = 3'd3,
    MODE_SOLID   = 3'd4,
    MODE_BLACK5  = 3'd5,
    MODE_BLACK6  = 3'd6,
    MODE_BLACK7  = 3'd7
  } pattern_e;

  logic [15:0]                h_cnt, v_cnt;
  logic [15:0]                active_h, x_base, y_line, x_k;
  logic [SEL_W-1:0]           sel_k;
  pattern_e                   mode_q;
  logic                       scroll_q;
  logic                       frame_start, de_d;
  logic [FRAME_CNT_WIDTH-1:0] frame_nxt;
  logic [DATA_WIDTH-1:0]      comp_r, comp_g, comp_b;
  logic [LANE_W-1:0]          r_d, g_d, b_d;

  always_comb begin
    frame_start = (h_cnt == '0) && (v_cnt == '0);
    frame_nxt   = o_frame_cnt + FRAME_CNT_WIDTH'(1);
    de_d        = (h_cnt >= H_ACT_START) && (h_cnt < H_ACT_END) &&
                  (v_cnt >= V_ACT_START) && (v_cnt < V_ACT_END);
    active_h    = h_cnt - H_ACT_START;
    x_base      = active_h * 16'(PIXELS_PER_CLK);
    y_line      = v_cnt - V_ACT_START;
  end

  always_comb begin
    r_d    = '0;
    g_d    = '0;
    b_d    = '0;
    x_k    = '0;
    sel_k  = '0;
    comp_r = '0;
    comp_g = '0;
    comp_b = '0;
    for (int unsigned k = 0; k < PIXELS_PER_CLK; k++) begin
      x_k    = x_base + 16'(k);
      sel_k  = SEL_W'(x_k + (scroll_q ? 16'(o_frame_cnt) : 16'h0));
      comp_r = '0;
      comp_g = '0;
      comp_b = '0;
      case (mode_q)
        MODE_BARS: begin
          comp_r = {DATA_WIDTH{sel_k[BAR_SHIFT]}};
          comp_g = {DATA_WIDTH{sel_k[BAR_SHIFT+1]}};
          comp_b = {DATA_WIDTH{sel_k[BAR_SHIFT+2]}};
        end
        MODE_HRAMP: begin
          comp_r[DATA_WIDTH-1 -: 8] = sel_k[7:0];
          comp_g = comp_r;
          comp_b = comp_r;
        end
        MODE_VRAMP: begin
          comp_r[DATA_WIDTH-1 -: 8] = y_line[7:0];
          comp_g = comp_r;
          comp_b = comp_r;
        end
        MODE_CHECKER: begin
          comp_r = {DATA_WIDTH{x_k[BAR_SHIFT] ^ y_line[BAR_SHIFT]}};
          comp_g = comp_r;
          comp_b = comp_r;
        end
        MODE_SOLID: begin
          comp_r = i_solid_rgb[2*DATA_WIDTH +: DATA_WIDTH];
          comp_g = i_solid_rgb[DATA_WIDTH +: DATA_WIDTH];
          comp_b = i_solid_rgb[0 +: DATA_WIDTH];
        end
        default: ;
      endcase
      r_d[k*DATA_WIDTH +: DATA_WIDTH] = comp_r;
      g_d[k*DATA_WIDTH +: DATA_WIDTH] = comp_g;
      b_d[k*DATA_WIDTH +: DATA_WIDTH] = comp_b;
    end
    if (!de_d || !o_init_done) begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
  end

  // Frame start is only the (0,0) cycle while enabled; outputs there use the
  // previous frame's latched mode, which is harmless because it is in sync.
  always_ff @(posedge i_sysclk or posedge i_arst) begin
    if (i_arst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      mode_q      <= MODE_BARS;
      scroll_q    <= 1'b0;
      o_vs        <= 1'b1;
      o_hs        <= 1'b1;
      o_de        <= 1'b0;
      o_valid     <= 1'b0;
      o_x         <= '0;
      o_y         <= '0;
      o_r         <= '0;
      o_g         <= '0;
      o_b         <= '0;
      o_frame_cnt <= '0;
      o_init_done <= 1'b0;
    end else if (!i_enable) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      o_vs    <= 1'b1;
      o_hs    <= 1'b1;
      o_de    <= 1'b0;
      o_valid <= 1'b0;
      o_x     <= '0;
      o_y     <= '0;
      o_r     <= '0;
      o_g     <= '0;
      o_b     <= '0;
    end else begin
      if (frame_start) begin
        mode_q      <= pattern_e'(i_mode);
        scroll_q    <= i_scroll_en;
        o_frame_cnt <= frame_nxt;
        if ({1'b0, frame_nxt} >= BLANK_LIMIT) o_init_done <= 1'b1;
      end
      o_hs    <= (h_cnt >= H_SYNC_END);
      o_vs    <= (v_cnt >= V_SYNC_END);
      o_de    <= de_d;
      o_valid <= de_d;
      o_x     <= de_d ? x_base : '0;
      o_y     <= de_d ? y_line : '0;
      o_r     <= r_d;
      o_g     <= g_d;
      o_b     <= b_d;
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 16'd1;
      end else begin
        h_cnt <= h_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pattern_gen.sv
// Bench for pattern_gen: two small-raster instances (1 and 2 lanes) checked
// against a time-index reference model plus directed scenario checks.
module tb_pattern_gen;

  localparam int HS = 2, HBP = 2, HA = 8, HFP = 2;
  localparam int VS = 1, VBP = 1, VA = 4, VFP = 1;
  localparam int HT = HS + HBP + HA + HFP;
  localparam int VT = VS + VBP + VA + VFP;
  localparam int FT = HT * VT;
  localparam logic [237:0] RST_VEC = {2'b11, 236'b0};

  int pp [2] = '{1, 2};
  int bs [2] = '{1, 2};
  int bl [2] = '{0, 3};

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        en = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic        scroll = 1'b0;
  logic [47:0] solid = 48'h0;

  logic a_vs, a_hs, a_de, a_valid, a_init;
  logic [15:0] a_x, a_y, a_r, a_g, a_b;
  logic [8:0]  a_fc;
  logic b_vs, b_hs, b_de, b_valid, b_init;
  logic [15:0] b_x, b_y;
  logic [31:0] b_r, b_g, b_b;
  logic [8:0]  b_fc;

  logic [237:0] dut_vec [2];
  logic [237:0] exp_vec [2];
  int tests = 0;
  int fails = 0;

  int  m_t [2], m_fc [2], m_mode [2];
  bit  m_init [2], m_scroll [2];

  always #5 clk = ~clk;

  pattern_gen #(.DATA_WIDTH(16), .PIXELS_PER_CLK(1), .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HBP),
    .H_FP(HFP), .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VBP), .V_FP(VFP), .BAR_SHIFT(1),
    .BLANK_FRAMES(0), .FRAME_CNT_WIDTH(9)) u_dut_a (
    .i_sysclk(clk), .i_arst(arst), .i_enable(en), .i_mode(mode), .i_scroll_en(scroll),
    .i_solid_rgb(solid), .o_vs(a_vs), .o_hs(a_hs), .o_de(a_de), .o_valid(a_valid),
    .o_x(a_x), .o_y(a_y), .o_r(a_r), .o_g(a_g), .o_b(a_b), .o_frame_cnt(a_fc),
    .o_init_done(a_init));

  pattern_gen #(.DATA_WIDTH(16), .PIXELS_PER_CLK(2), .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HBP),
    .H_FP(HFP), .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VBP), .V_FP(VFP), .BAR_SHIFT(2),
    .BLANK_FRAMES(3), .FRAME_CNT_WIDTH(9)) u_dut_b (
    .i_sysclk(clk), .i_arst(arst), .i_enable(en), .i_mode(mode), .i_scroll_en(scroll),
    .i_solid_rgb(solid), .o_vs(b_vs), .o_hs(b_hs), .o_de(b_de), .o_valid(b_valid),
    .o_x(b_x), .o_y(b_y), .o_r(b_r), .o_g(b_g), .o_b(b_b), .o_frame_cnt(b_fc),
    .o_init_done(b_init));

  assign dut_vec[0] = {a_vs, a_hs, a_de, a_valid, a_x, a_y, {48'b0, a_r}, {48'b0, a_g},
                       {48'b0, a_b}, a_fc, a_init};
  assign dut_vec[1] = {b_vs, b_hs, b_de, b_valid, b_x, b_y, {32'b0, b_r}, {32'b0, b_g},
                       {32'b0, b_b}, b_fc, b_init};

  // Colour of one pixel straight from the pattern rules.
  function automatic logic [47:0] pixel(int shift, int x, int y, int md, bit scr, int fc,
                                         logic [47:0] sol);
    int sel = (x + (scr ? fc : 0)) % 65536;
    logic [15:0] lvl;
    case (md)
      0: return {((sel >> shift) % 2 == 1) ? 16'hFFFF : 16'h0,
                 ((sel >> (shift + 1)) % 2 == 1) ? 16'hFFFF : 16'h0,
                 ((sel >> (shift + 2)) % 2 == 1) ? 16'hFFFF : 16'h0};
      1: begin lvl = 16'((sel % 256) * 256); return {lvl, lvl, lvl}; end
      2: begin lvl = 16'((y % 256) * 256); return {lvl, lvl, lvl}; end
      3: return ((((x >> shift) ^ (y >> shift)) % 2) == 1) ? {48{1'b1}} : 48'h0;
      4: return sol;
      default: return 48'h0;
    endcase
  endfunction

  function automatic logic [237:0] model_out(int p, int shift, int h, int v, int md, bit scr,
                                             int fc, bit init, logic [47:0] sol);
    logic [63:0] er = '0, eg = '0, eb = '0;
    logic [47:0] px;
    bit de = (h >= HS + HBP) && (h < HS + HBP + HA) && (v >= VS + VBP) && (v < VS + VBP + VA);
    int ah = h - (HS + HBP);
    int ay = v - (VS + VBP);
    if (de && init)
      for (int k = 0; k < p; k++) begin
        px = pixel(shift, p * ah + k, ay, md, scr, fc, sol);
        er[k*16 +: 16] = px[47:32];
        eg[k*16 +: 16] = px[31:16];
        eb[k*16 +: 16] = px[15:0];
      end
    return {v >= VS, h >= HS, de, de, de ? 16'(p * ah) : 16'h0, de ? 16'(ay) : 16'h0,
            er, eg, eb, 9'(fc), init};
  endfunction

  // Reference: position is a cycle index within the frame, not h/v counters.
  always @(posedge clk or posedge arst) begin
    for (int i = 0; i < 2; i++) begin
      if (arst) begin
        m_t[i] = 0; m_fc[i] = 0; m_init[i] = 1'b0; m_mode[i] = 0; m_scroll[i] = 1'b0;
        exp_vec[i] = RST_VEC;
      end else if (!en) begin
        m_t[i] = 0;
        exp_vec[i] = {2'b11, 226'b0, 9'(m_fc[i]), m_init[i]};
      end else begin
        if (m_t[i] == 0) begin
          m_fc[i] = (m_fc[i] + 1) % 512;
          m_mode[i] = int'(mode);
          m_scroll[i] = scroll;
          if (m_fc[i] >= bl[i]) m_init[i] = 1'b1;
        end
        exp_vec[i] = model_out(pp[i], bs[i], m_t[i] % HT, m_t[i] / HT, m_mode[i], m_scroll[i],
                               m_fc[i], m_init[i], solid);
        m_t[i] = (m_t[i] + 1) % FT;
      end
    end
  end

  task automatic test_reset;
    repeat (2) @(negedge clk);
    en = 1'b1;
    repeat (2) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (dut_vec[i] !== RST_VEC) begin
          fails++; $display("FAIL reset inst%0d got=%h exp=%h", i, dut_vec[i], RST_VEC);
        end
      end
    end
  endtask

  task automatic test_timing;
    int hs_low = 0, vs_low = 0, de_cnt = 0;
    en = 1'b0; mode = 3'd0; scroll = 1'b0;
    arst = 1'b0;
    @(negedge clk);
    tests++;
    if (dut_vec[0] !== RST_VEC) begin
      fails++; $display("FAIL idle_after_reset got=%h exp=%h", dut_vec[0], RST_VEC);
    end
    en = 1'b1;
    for (int c = 0; c < FT; c++) begin
      @(negedge clk);
      if (c == 0) begin
        tests++;
        if (a_fc !== 9'd1 || a_hs !== 1'b0 || a_vs !== 1'b0) begin
          fails++; $display("FAIL first_frame fc=%0d hs=%b vs=%b exp fc=1 hs=0 vs=0", a_fc, a_hs, a_vs);
        end
      end
      hs_low += (a_hs == 1'b0) ? 1 : 0;
      vs_low += (a_vs == 1'b0) ? 1 : 0;
      de_cnt += (a_de == 1'b1) ? 1 : 0;
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (dut_vec[i] !== exp_vec[i]) begin
          fails++; $display("FAIL timing inst%0d @%0t got=%h exp=%h", i, $time, dut_vec[i], exp_vec[i]);
        end
      end
    end
    tests++;
    if (hs_low != 2 * VT || vs_low != HT || de_cnt != HA * VA) begin
      fails++; $display("FAIL frame_counts hs_low=%0d vs_low=%0d de=%0d exp %0d %0d %0d",
                        hs_low, vs_low, de_cnt, 2 * VT, HT, HA * VA);
    end
  endtask

  task automatic test_bars;
    logic [15:0] exp_r [8] = '{16'h0, 16'h0, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 16'hFFFF, 16'hFFFF};
    logic [15:0] exp_g [8] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    int guard = 0;
    do begin @(negedge clk); guard++; end while (a_de !== 1'b1 && guard < 4 * FT);
    tests++;
    if (a_de !== 1'b1) begin fails++; $display("FAIL bars_wait_de got=%b exp=1", a_de); end
    for (int j = 0; j < 8; j++) begin
      tests++;
      if (a_x !== 16'(j) || a_r !== exp_r[j] || a_g !== exp_g[j] || a_b !== 16'h0) begin
        fails++; $display("FAIL bars x=%0d got x=%0d r=%h g=%h b=%h exp r=%h g=%h b=0000",
                          j, a_x, a_r, a_g, a_b, exp_r[j], exp_g[j]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_scroll_mode_change;
    scroll = 1'b1;
    for (int c = 0; c < 3 * FT; c++) begin
      @(negedge clk);
      if (c == FT + FT / 2) begin mode = 3'd4; solid = {$urandom, $urandom} & {48{1'b1}}; end
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (dut_vec[i] !== exp_vec[i]) begin
          fails++; $display("FAIL scroll_mode inst%0d @%0t got=%h exp=%h", i, $time, dut_vec[i], exp_vec[i]);
        end
      end
    end
  endtask

  task automatic test_blanking;
    int nz = 0, frame;
    en = 1'b0; mode = 3'd1; scroll = 1'b0;
    @(negedge clk); arst = 1'b1;
    @(negedge clk); arst = 1'b0; en = 1'b1;
    for (int c = 0; c < 4 * FT; c++) begin
      @(negedge clk);
      frame = c / FT + 1;
      tests++;
      if (b_init !== (frame >= 3) || b_fc !== 9'(frame)) begin
        fails++; $display("FAIL blank_init c=%0d got init=%b fc=%0d exp init=%b fc=%0d",
                          c, b_init, b_fc, frame >= 3, frame);
      end
      if (frame < 3) begin
        tests++;
        if (b_r !== 32'h0 || b_g !== 32'h0 || b_b !== 32'h0) begin
          fails++; $display("FAIL blank_rgb c=%0d got r=%h g=%h b=%h exp 0", c, b_r, b_g, b_b);
        end
      end
      if (frame == 3 && b_de === 1'b1 && b_r !== 32'h0) nz++;
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (dut_vec[i] !== exp_vec[i]) begin
          fails++; $display("FAIL blanking inst%0d @%0t got=%h exp=%h", i, $time, dut_vec[i], exp_vec[i]);
        end
      end
    end
    tests++;
    if (nz != HA * VA) begin fails++; $display("FAIL frame3_pattern got=%0d nonblack exp=%0d", nz, HA * VA); end
  endtask

  task automatic test_dual_lane;
    int guard = 0;
    do begin @(negedge clk); guard++; end while (b_de !== 1'b1 && guard < 4 * FT);
    tests++;
    if (b_de !== 1'b1) begin fails++; $display("FAIL lane_wait_de got=%b exp=1", b_de); end
    for (int j = 0; j < HA; j++) begin
      tests++;
      if (b_x !== 16'(2 * j) || b_r[15:0] !== 16'((2 * j) * 256) ||
          b_r[31:16] !== 16'((2 * j + 1) * 256) || b_b !== b_r) begin
        fails++; $display("FAIL dual_lane j=%0d got x=%0d r=%h b=%h exp x=%0d lane0=%h lane1=%h",
                          j, b_x, b_r, b_b, 2 * j, 16'((2 * j) * 256), 16'((2 * j + 1) * 256));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_enable_reset;
    int guard = 0;
    do begin @(negedge clk); guard++; end while (a_de !== 1'b1 && guard < 4 * FT);
    repeat (3) @(negedge clk);
    en = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tests++;
      if (a_vs !== 1'b1 || a_hs !== 1'b1 || a_de !== 1'b0 || a_r !== 16'h0 || b_de !== 1'b0 ||
          a_init !== 1'b1 || b_init !== 1'b1) begin
        fails++; $display("FAIL idle c=%0d got vs=%b hs=%b de=%b r=%h init=%b/%b exp 1 1 0 0 1/1",
                          c, a_vs, a_hs, a_de, a_r, a_init, b_init);
      end
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (dut_vec[i] !== exp_vec[i]) begin
          fails++; $display("FAIL idle_model inst%0d got=%h exp=%h", i, dut_vec[i], exp_vec[i]);
        end
      end
    end
    en = 1'b1;
    for (int c = 0; c < FT / 2; c++) begin
      @(negedge clk);
      if (c == 0) begin
        tests++;
        if (a_hs !== 1'b0 || a_vs !== 1'b0) begin
          fails++; $display("FAIL restart got hs=%b vs=%b exp 0 0", a_hs, a_vs);
        end
      end
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (dut_vec[i] !== exp_vec[i]) begin
          fails++; $display("FAIL restart_model inst%0d got=%h exp=%h", i, dut_vec[i], exp_vec[i]);
        end
      end
    end
    arst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (dut_vec[i] !== RST_VEC) begin
        fails++; $display("FAIL midframe_reset inst%0d got=%h exp=%h", i, dut_vec[i], RST_VEC);
      end
    end
    @(negedge clk);
    arst = 1'b0;
  endtask

  task automatic test_random;
    int act, n;
    for (int it = 0; it < 40; it++) begin
      act = $urandom_range(0, 9);
      if (act <= 5) begin
        mode = 3'($urandom_range(0, 7));
        scroll = 1'($urandom_range(0, 1));
        solid = {$urandom, $urandom} & {48{1'b1}};
      end else if (act <= 7) begin
        en = 1'b0;
      end else begin
        arst = 1'b1;
      end
      n = $urandom_range(20, 200);
      for (int c = 0; c < n; c++) begin
        @(negedge clk);
        if (c == 2) arst = 1'b0;
        if (c == 1 + (n % 17)) en = 1'b1;
        for (int i = 0; i < 2; i++) begin
          tests++;
          if (dut_vec[i] !== exp_vec[i]) begin
            fails++; $display("FAIL random inst%0d it=%0d @%0t got=%h exp=%h", i, it, $time,
                              dut_vec[i], exp_vec[i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_timing;
    test_bars;
    test_scroll_mode_change;
    test_blanking;
    test_dual_lane;
    test_enable_reset;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
